voxel_port_arbiter: RTL and testbench

VOXEL_PORT_ARBITER -- requirements
Module: voxel_port_arbiter

---
 rtl/voxel_port_arbiter.sv | 149 ++++++++++++++
 tb/tb_voxel_port_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/voxel_port_arbiter.sv
// voxel_port_arbiter
// Round-robin arbiter that lets three requesters share one cube display
// write port. A winning requester's voxel address and colour are latched and
// issued with a single-cycle wr_en strobe. The arbiter then waits for wr_ack,
// or aborts with a timeout_err pulse after TIMEOUT cycles.
//
// Ports
//   clk          system clock, all logic on the rising edge
//   resetn       synchronous active-low reset
//   req[2:0]     write requests, bit i belongs to requester i
//   req_x/y/z/c  packed 3-bit fields, requester i at [3i+2:3i]
//   grant[2:0]   one-hot, held high for the requester being served
//   wr_en        single-cycle write strobe
//   wr_x/y/z/c   latched voxel address and colour
//   wr_ack       downstream completion of the issued write
//   busy         high whenever the FSM is not idle
//   timeout_err  one-cycle pulse when a write is aborted
module voxel_port_arbiter #(
  parameter int TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [2:0] req,
  input  logic [8:0] req_x,
  input  logic [8:0] req_y,
  input  logic [8:0] req_z,
  input  logic [8:0] req_c,
  output logic [2:0] grant,
  output logic       wr_en,
  output logic [2:0] wr_x,
  output logic [2:0] wr_y,
  output logic [2:0] wr_z,
  output logic [2:0] wr_c,
  input  logic       wr_ack,
  output logic       busy,
  output logic       timeout_err
);

  // The FSM leaves WAIT when the timer hits TIMEOUT-1, so clog2(TIMEOUT)
  // bits are enough and the timer never wraps.
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t        state, state_next;
  logic [2:0]    grant_next;
  logic [2:0]    x_next, y_next, z_next, c_next;
  logic [1:0]    ptr, ptr_next;
  logic [1:0]    cur, cur_next;
  logic [TW-1:0] timer, timer_next;
  logic          terr_next;

  logic [1:0]    next1, next2, win;

  function automatic logic [2:0] pick3(input logic [8:0] v, input logic [1:0] i);
    case (i)
      2'd0:    pick3 = v[2:0];
      2'd1:    pick3 = v[5:3];
      default: pick3 = v[8:6];
    endcase
  endfunction

  // Round-robin scan starts just after the last served requester (ptr) and
  // ends on ptr itself, so a requester holding req yields to the others.
  always_comb begin
    next1 = (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
    next2 = (next1 == 2'd2) ? 2'd0 : next1 + 2'd1;
    if (req[next1])      win = next1;
    else if (req[next2]) win = next2;
    else                 win = ptr;
  end

  always_comb begin
    state_next = state;
    grant_next = grant;
    x_next     = wr_x;
    y_next     = wr_y;
    z_next     = wr_z;
    c_next     = wr_c;
    ptr_next   = ptr;
    cur_next   = cur;
    timer_next = timer;
    terr_next  = 1'b0;
    case (state)
      IDLE: begin
        grant_next = 3'b000;
        if (|req) begin
          grant_next = 3'b001 << win;
          cur_next   = win;
          x_next     = pick3(req_x, win);
          y_next     = pick3(req_y, win);
          z_next     = pick3(req_z, win);
          c_next     = pick3(req_c, win);
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        timer_next = '0;
        state_next = WAIT;
      end
      WAIT: begin
        if (timer != TLAST) timer_next = timer + TW'(1);
        // Ack takes priority over a simultaneous timeout.
        if (wr_ack) begin
          grant_next = 3'b000;
          ptr_next   = cur;
          state_next = IDLE;
        end else if (timer == TLAST) begin
          terr_next  = 1'b1;
          grant_next = 3'b000;
          ptr_next   = cur;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      grant       <= 3'b000;
      wr_x        <= 3'd0;
      wr_y        <= 3'd0;
      wr_z        <= 3'd0;
      wr_c        <= 3'd0;
      ptr         <= 2'd2;
      cur         <= 2'd0;
      timer       <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_next;
      grant       <= grant_next;
      wr_x        <= x_next;
      wr_y        <= y_next;
      wr_z        <= z_next;
      wr_c        <= c_next;
      ptr         <= ptr_next;
      cur         <= cur_next;
      timer       <= timer_next;
      timeout_err <= terr_next;
    end
  end

  assign wr_en = (state == ISSUE);
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_voxel_port_arbiter.sv
// tb_voxel_port_arbiter
// Self-checking bench for voxel_port_arbiter (TIMEOUT = 8). Expected writes
// are pushed to a scoreboard when requests are driven. A monitor pops one
// entry per wr_en strobe and checks the grant, address and colour.
module tb_voxel_port_arbiter;

  logic       clk;
  logic       resetn;
  logic [2:0] req;
  logic [8:0] req_x, req_y, req_z, req_c;
  logic [2:0] grant;
  logic       wr_en;
  logic [2:0] wr_x, wr_y, wr_z, wr_c;
  logic       wr_ack;
  logic       busy;
  logic       timeout_err;

  typedef struct {
    logic [2:0] g;
    logic [2:0] x;
    logic [2:0] y;
    logic [2:0] z;
    logic [2:0] c;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  logic [2:0] dx[3], dy[3], dz[3], dc[3];

  voxel_port_arbiter #(.TIMEOUT(8)) dut (
    .clk(clk), .resetn(resetn), .req(req),
    .req_x(req_x), .req_y(req_y), .req_z(req_z), .req_c(req_c),
    .grant(grant), .wr_en(wr_en),
    .wr_x(wr_x), .wr_y(wr_y), .wr_z(wr_z), .wr_c(wr_c),
    .wr_ack(wr_ack), .busy(busy), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus();
    req_x = {dx[2], dx[1], dx[0]};
    req_y = {dy[2], dy[1], dy[0]};
    req_z = {dz[2], dz[1], dz[0]};
    req_c = {dc[2], dc[1], dc[0]};
  endtask

  task automatic push_expect(input int i);
    exp_t e;
    e.g = 3'b001 << i;
    e.x = dx[i];
    e.y = dy[i];
    e.z = dz[i];
    e.c = dc[i];
    sb.push_back(e);
  endtask

  // Every wr_en strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (sb.size() == 0) begin
        check_output("spurious_wr_en", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_output("sb_grant", grant, e.g);
        check_output("sb_wr_x", wr_x, e.x);
        check_output("sb_wr_y", wr_y, e.y);
        check_output("sb_wr_z", wr_z, e.z);
        check_output("sb_wr_c", wr_c, e.c);
      end
    end
  end

  initial begin
    int order[4];
    order = '{0, 1, 2, 0};
    resetn = 1'b0;
    req    = 3'b000;
    wr_ack = 1'b0;
    dx = '{3'd1, 3'd5, 3'd6};
    dy = '{3'd2, 3'd2, 3'd6};
    dz = '{3'd3, 3'd7, 3'd6};
    dc = '{3'd4, 3'd3, 3'd0};
    apply_stimulus();

    // Reset state
    tick();
    tick();
    check_output("rst_grant", grant, 3'b000);
    check_output("rst_wr_en", wr_en, 1'b0);
    check_output("rst_busy", busy, 1'b0);
    check_output("rst_terr", timeout_err, 1'b0);
    check_output("rst_wr_x", wr_x, 3'd0);
    check_output("rst_wr_c", wr_c, 3'd0);
    resetn = 1'b1;

    // All three requesting: round-robin 001, 010, 100, 001
    req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      push_expect(order[k]);
      tick();
      check_output("rr_grant", grant, 3'b001 << order[k]);
      check_output("rr_wr_en", wr_en, 1'b1);
      check_output("rr_busy", busy, 1'b1);
      if (k == 3) req = 3'b000;
      tick();
      check_output("rr_wr_en_low", wr_en, 1'b0);
      wr_ack = 1'b1;
      tick();
      wr_ack = 1'b0;
      check_output("rr_idle_grant", grant, 3'b000);
      check_output("rr_idle_busy", busy, 1'b0);
    end

    // Single requester 1, explicit data check
    req = 3'b010;
    push_expect(1);
    tick();
    check_output("r1_wr_en", wr_en, 1'b1);
    check_output("r1_grant", grant, 3'b010);
    check_output("r1_wr_x", wr_x, 3'd5);
    check_output("r1_wr_y", wr_y, 3'd2);
    check_output("r1_wr_z", wr_z, 3'd7);
    check_output("r1_wr_c", wr_c, 3'd3);
    req = 3'b000;
    tick();
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
    check_output("r1_done_busy", busy, 1'b0);

    // Timeout: ack during ISSUE is ignored, no ack in WAIT
    req = 3'b001;
    push_expect(0);
    tick();
    req = 3'b000;
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
    check_output("to_entry_busy", busy, 1'b1);
    check_output("to_entry_terr", timeout_err, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check_output($sformatf("to_terr_%0d", k), timeout_err, (k == 8) ? 1 : 0);
      check_output($sformatf("to_busy_%0d", k), busy, (k < 8) ? 1 : 0);
    end
    tick();
    check_output("to_after_terr", timeout_err, 1'b0);
    check_output("to_after_grant", grant, 3'b000);
    check_output("to_after_busy", busy, 1'b0);

    // Ack on the last timer cycle wins over timeout; colour 0 passes through
    req = 3'b100;
    push_expect(2);
    tick();
    check_output("race_grant", grant, 3'b100);
    check_output("race_wr_c0", wr_c, 3'd0);
    req = 3'b000;
    tick();
    repeat (7) tick();
    check_output("race_busy", busy, 1'b1);
    check_output("race_terr_pre", timeout_err, 1'b0);
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
    check_output("race_terr", timeout_err, 1'b0);
    check_output("race_busy_done", busy, 1'b0);
    tick();
    check_output("race_terr_late", timeout_err, 1'b0);

    // Request dropped and data changed during WAIT
    req = 3'b001;
    push_expect(0);
    tick();
    tick();
    req = 3'b000;
    dx[0] = 3'd7;
    apply_stimulus();
    repeat (3) begin
      tick();
      check_output("hold_wr_x", wr_x, 3'd1);
      check_output("hold_grant", grant, 3'b001);
      check_output("hold_wr_en", wr_en, 1'b0);
    end
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
    check_output("hold_busy", busy, 1'b0);
    repeat (3) tick();
    check_output("hold_idle_wr_x", wr_x, 3'd1);
    check_output("hold_idle_grant", grant, 3'b000);
    dx[0] = 3'd1;
    apply_stimulus();

    // Reset during WAIT, then 3'b110 goes to requester 1 first
    req = 3'b010;
    push_expect(1);
    tick();
    req = 3'b000;
    tick();
    resetn = 1'b0;
    tick();
    check_output("wrst_grant", grant, 3'b000);
    check_output("wrst_wr_en", wr_en, 1'b0);
    check_output("wrst_busy", busy, 1'b0);
    check_output("wrst_terr", timeout_err, 1'b0);
    check_output("wrst_wr_x", wr_x, 3'd0);
    check_output("wrst_wr_y", wr_y, 3'd0);
    check_output("wrst_wr_z", wr_z, 3'd0);
    check_output("wrst_wr_c", wr_c, 3'd0);
    resetn = 1'b1;
    req = 3'b110;
    push_expect(1);
    tick();
    check_output("wrst_first_grant", grant, 3'b010);
    req = 3'b000;
    tick();
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
    check_output("wrst_done_terr", timeout_err, 1'b0);
    repeat (2) tick();
    check_output("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
